// File: rtl/warp_dispatcher_pkg.sv
// Shared types and constants for the warp dispatcher: kernel descriptor,
// the "no warp" id, and the dispatcher FSM state encoding.
package warp_dispatcher_pkg;

  localparam int unsigned WARP_ID_W = 4;
  localparam int unsigned PC_W      = 32;

  localparam logic [WARP_ID_W-1:0] WARP_ID_NONE = 4'hF;

  typedef struct packed {
    logic [WARP_ID_W-1:0] warp_id;
    logic [PC_W-1:0]      start_pc;
  } kernel_t;

  localparam kernel_t KERNEL_NONE = '{warp_id: WARP_ID_NONE, start_pc: '0};

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LAUNCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_RUN        = 3'd3;
  localparam logic [2:0] ST_RETIRE     = 3'd4;

endpackage

// File: rtl/warp_dispatcher_kernel_fifo.sv
// Synchronous FIFO of kernel descriptors; no write-to-read bypass, so an
// entry written into an empty FIFO becomes visible on the following cycle.
module kernel_fifo
  import warp_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  kernel_t               push_data,
  input  logic                  pop,
  output kernel_t               pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  kernel_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Launch stage for simd_core: queues kernels, launches one warp at a time,
// and retires it on the core's matching finished handshake or a start timeout.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH   = 8,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        submit_valid,
  input  kernel_t                     submit_kernel,
  output logic                        submit_ready,
  output kernel_t                     kernel_out,
  output logic                        launch,
  input  logic                        core_finished,
  input  logic [WARP_ID_W-1:0]        core_warp_id,
  output logic                        done_valid,
  output logic [WARP_ID_W-1:0]        done_warp_id,
  output logic                        done_timeout,
  output logic                        busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int unsigned TIMER_W = $clog2(START_TIMEOUT) + 1;

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [TIMER_W-1:0] timer_inc;
  logic               timeout_flag;
  logic               timeout_flag_next;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  kernel_t            fifo_head;

  kernel_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (submit_valid),
    .push_data (submit_kernel),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

  assign submit_ready = !fifo_full;
  assign busy         = (state != ST_IDLE) || !fifo_empty;
  assign timer_inc    = timer + TIMER_W'(1);

  // Next-state logic. The core idles with finished high, so a warp only counts
  // as started once finished drops; a stale high level never retires it.
  always_comb begin
    state_next        = state;
    timer_next        = timer;
    timeout_flag_next = timeout_flag;
    fifo_pop          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_next        = '0;
        timeout_flag_next = 1'b0;
        state_next        = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!core_finished) begin
          state_next = ST_RUN;
        end else begin
          timer_next = timer_inc;
          if (timer_inc == TIMER_W'(START_TIMEOUT - 1)) begin
            timeout_flag_next = 1'b1;
            state_next        = ST_RETIRE;
          end
        end
      end
      ST_RUN: begin
        if (core_finished && (core_warp_id == kernel_out.warp_id)) state_next = ST_RETIRE;
      end
      ST_RETIRE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, timer and registered outputs aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      timeout_flag <= 1'b0;
      kernel_out   <= KERNEL_NONE;
      launch       <= 1'b0;
      done_valid   <= 1'b0;
      done_timeout <= 1'b0;
      done_warp_id <= WARP_ID_NONE;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      timeout_flag <= timeout_flag_next;
      if (fifo_pop) kernel_out <= fifo_head;
      launch       <= (state_next == ST_LAUNCH);
      done_valid   <= (state_next == ST_RETIRE);
      done_timeout <= (state_next == ST_RETIRE) && timeout_flag_next;
      if (state_next == ST_RETIRE) done_warp_id <= kernel_out.warp_id;
    end
  end

endmodule
